// File: rtl/jk_pulse_monitor.sv
// jk_pulse_monitor
//   Watches the Q output of a JK flip-flop in the same clock domain.
//   It counts rising and falling edges (saturating) and measures the width of
//   each complete high pulse. It flags Q as stuck after TIMEOUT cycles with no
//   edge. Every output is driven straight from a register.
module jk_pulse_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIDTH_W = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic               q,
  input  logic               clr,
  output logic [CNT_W-1:0]   rise_cnt,
  output logic [CNT_W-1:0]   fall_cnt,
  output logic [WIDTH_W-1:0] last_high,
  output logic               width_vld,
  output logic               stuck,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_HIGH     = 2'd1,
    ST_STUCK_LO = 2'd2,
    ST_STUCK_HI = 2'd3
  } state_e;

  localparam int                 IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;
  localparam logic [WIDTH_W-1:0] WIDTH_ONE = WIDTH_W'(1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0]  IDLE_ONE  = IDLE_W'(1);

  state_e             state_q,     state_d;
  logic               q_prev_q,    q_prev_d;
  logic [CNT_W-1:0]   rise_cnt_q,  rise_cnt_d;
  logic [CNT_W-1:0]   fall_cnt_q,  fall_cnt_d;
  logic [WIDTH_W-1:0] last_high_q, last_high_d;
  logic [WIDTH_W-1:0] run_cnt_q,   run_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q,  idle_cnt_d;
  logic               width_vld_q, width_vld_d;
  logic               stuck_q,     stuck_d;
  logic               partial_q,   partial_d;

  logic rise, fall;

  // Edge detection against the previous sample of q.
  assign rise = q & ~q_prev_q;
  assign fall = ~q & q_prev_q;

  // State register and all statistics registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOW;
      q_prev_q    <= 1'b0;
      rise_cnt_q  <= '0;
      fall_cnt_q  <= '0;
      last_high_q <= '0;
      run_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      width_vld_q <= 1'b0;
      stuck_q     <= 1'b0;
      partial_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_prev_q    <= q_prev_d;
      rise_cnt_q  <= rise_cnt_d;
      fall_cnt_q  <= fall_cnt_d;
      last_high_q <= last_high_d;
      run_cnt_q   <= run_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      width_vld_q <= width_vld_d;
      stuck_q     <= stuck_d;
      partial_q   <= partial_d;
    end
  end

  // Next-state logic: clr first, then edge handling, then edgeless timeout.
  // NOTE: every signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    q_prev_d    = q;
    rise_cnt_d  = rise_cnt_q;
    fall_cnt_d  = fall_cnt_q;
    last_high_d = last_high_q;
    run_cnt_d   = run_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    width_vld_d = 1'b0;
    stuck_d     = stuck_q;
    partial_d   = partial_q;

    if (clr) begin
      // Restart the statistics from the current level of q. A pulse that is
      // already high is marked partial so that its width is never reported.
      rise_cnt_d  = '0;
      fall_cnt_d  = '0;
      last_high_d = '0;
      run_cnt_d   = '0;
      idle_cnt_d  = '0;
      stuck_d     = 1'b0;
      partial_d   = q;
      state_d     = q ? ST_HIGH : ST_LOW;
    end else if (rise) begin
      rise_cnt_d = (rise_cnt_q == CNT_MAX) ? rise_cnt_q : rise_cnt_q + CNT_ONE;
      run_cnt_d  = WIDTH_ONE;
      idle_cnt_d = '0;
      stuck_d    = 1'b0;
      state_d    = ST_HIGH;
    end else if (fall) begin
      fall_cnt_d = (fall_cnt_q == CNT_MAX) ? fall_cnt_q : fall_cnt_q + CNT_ONE;
      idle_cnt_d = '0;
      stuck_d    = 1'b0;
      state_d    = ST_LOW;
      run_cnt_d  = '0;
      if (partial_q) begin
        partial_d = 1'b0;
      end else begin
        last_high_d = run_cnt_q;
        width_vld_d = 1'b1;
      end
    end else begin
      idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IDLE_ONE;
      if (q) begin
        run_cnt_d = (run_cnt_q == WIDTH_MAX) ? run_cnt_q : run_cnt_q + WIDTH_ONE;
      end
      // The TIMEOUT-th edgeless cycle moves the FSM to the matching stuck state.
      if (idle_cnt_d == IDLE_MAX) begin
        stuck_d = 1'b1;
        case (state_q)
          ST_LOW:  state_d = ST_STUCK_LO;
          ST_HIGH: state_d = ST_STUCK_HI;
          default: state_d = state_q;
        endcase
      end
    end
  end

  assign rise_cnt  = rise_cnt_q;
  assign fall_cnt  = fall_cnt_q;
  assign last_high = last_high_q;
  assign width_vld = width_vld_q;
  assign stuck     = stuck_q;
  assign state     = state_q;

endmodule

// File: tb/tb_jk_pulse_monitor.sv
// tb_jk_pulse_monitor
//   A sequence of directed steps followed by random level bursts.
//   Every output is compared each cycle against a behavioural model.
//   The model tracks run lengths and time since the last edge.
module tb_jk_pulse_monitor;

  localparam int CNT_W   = 2;
  localparam int WIDTH_W = 5;
  localparam int TIMEOUT = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int WMAX    = (1 << WIDTH_W) - 1;

  logic               clk;
  logic               rst;
  logic               q;
  logic               clr;
  logic [CNT_W-1:0]   rise_cnt;
  logic [CNT_W-1:0]   fall_cnt;
  logic [WIDTH_W-1:0] last_high;
  logic               width_vld;
  logic               stuck;
  logic [1:0]         state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the last sampled level, the event counts, the length of
  // the current run of ones, and the number of cycles since the last edge.
  int m_prev, m_rise, m_fall, m_last, m_vld, m_ones, m_edgeless, m_partial;

  jk_pulse_monitor #(
    .CNT_W   (CNT_W),
    .WIDTH_W (WIDTH_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .q         (q),
    .clr       (clr),
    .rise_cnt  (rise_cnt),
    .fall_cnt  (fall_cnt),
    .last_high (last_high),
    .width_vld (width_vld),
    .stuck     (stuck),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_rise = 0; m_fall = 0; m_last = 0; m_vld = 0;
    m_ones = 0; m_edgeless = 0; m_partial = 0;
  endtask

  task automatic model_clock(input int qv, input int cv);
    if (cv != 0) begin
      m_rise = 0; m_fall = 0; m_last = 0; m_vld = 0;
      m_ones = 0; m_edgeless = 0; m_partial = qv;
    end else begin
      m_vld = 0;
      if (qv != m_prev) begin
        m_edgeless = 0;
        if (qv != 0) begin
          m_rise = sat(m_rise + 1, CMAX);
          m_ones = 1;
        end else begin
          m_fall = sat(m_fall + 1, CMAX);
          if (m_partial == 0) begin
            m_last = sat(m_ones, WMAX);
            m_vld  = 1;
          end
          m_partial = 0;
          m_ones    = 0;
        end
      end else begin
        m_edgeless++;
        if (qv != 0) m_ones++;
      end
    end
    m_prev = qv;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    int exp_stuck;
    exp_stuck = (m_edgeless >= TIMEOUT) ? 1 : 0;
    check({tag, ".rise_cnt"},  32'(rise_cnt),  32'(m_rise));
    check({tag, ".fall_cnt"},  32'(fall_cnt),  32'(m_fall));
    check({tag, ".last_high"}, 32'(last_high), 32'(m_last));
    check({tag, ".width_vld"}, 32'(width_vld), 32'(m_vld));
    check({tag, ".stuck"},     32'(stuck),     32'(exp_stuck));
    check({tag, ".state"},     32'(state),     32'(2 * exp_stuck + m_prev));
  endtask

  // Called at a falling edge: drive the inputs, clock the model at the
  // rising edge, then compare at the next falling edge.
  task automatic tick(input logic qv, input logic cv, input string tag);
    q   = qv;
    clr = cv;
    @(posedge clk);
    model_clock(int'(qv), int'(cv));
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    int lvl, len;
    rst = 1'b0;
    q   = 1'b0;
    clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("in_reset");
    rst = 1'b1;

    // Step 1: quiet line after reset.
    repeat (5) tick(1'b0, 1'b0, "idle_low");
    check("idle_low.state_const", 32'(state), 32'd0);

    // Step 2: a three-cycle pulse.
    repeat (3) tick(1'b1, 1'b0, "pulse3");
    tick(1'b0, 1'b0, "pulse3_fall");
    check("pulse3.last_high_const", 32'(last_high), 32'd3);
    check("pulse3.vld_at_fall", 32'(width_vld), 32'd1);
    tick(1'b0, 1'b0, "pulse3_after");
    check("pulse3.vld_one_cycle", 32'(width_vld), 32'd0);

    // Step 3: a ten-cycle high level that crosses the timeout.
    tick(1'b0, 1'b1, "clr3");
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0, "long_high");
      if (i == 8) check("timeout.not_yet", 32'(stuck), 32'd0);
      if (i == 9) begin
        check("timeout.stuck", 32'(stuck), 32'd1);
        check("timeout.state", 32'(state), 32'd3);
      end
    end
    tick(1'b0, 1'b0, "long_fall");
    check("timeout.fall_stuck", 32'(stuck), 32'd0);
    check("timeout.fall_state", 32'(state), 32'd0);
    check("timeout.fall_width", 32'(last_high), 32'd10);

    // Step 4: five one-cycle pulses saturate the two-bit counters.
    tick(1'b0, 1'b1, "clr4");
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, "sat_rise");
      tick(1'b0, 1'b0, "sat_fall");
    end
    check("sat.rise_cnt", 32'(rise_cnt), 32'd3);
    check("sat.fall_cnt", 32'(fall_cnt), 32'd3);

    // Step 5: clr in the middle of a pulse hides that pulse's width.
    tick(1'b0, 1'b1, "clr5");
    tick(1'b1, 1'b0, "part_high");
    tick(1'b1, 1'b0, "part_high");
    tick(1'b1, 1'b1, "part_clr");
    check("partial.rise_cleared", 32'(rise_cnt), 32'd0);
    tick(1'b1, 1'b0, "part_high2");
    tick(1'b0, 1'b0, "part_fall");
    check("partial.fall_cnt", 32'(fall_cnt), 32'd1);
    check("partial.last_high", 32'(last_high), 32'd0);
    check("partial.width_vld", 32'(width_vld), 32'd0);

    // Step 6: a pulse longer than the width counter can hold.
    tick(1'b0, 1'b1, "clr6");
    repeat (40) tick(1'b1, 1'b0, "wide_high");
    tick(1'b0, 1'b0, "wide_fall");
    check("wide.last_high_sat", 32'(last_high), 32'(WMAX));

    // Step 7: asynchronous reset in the middle of a pulse.
    tick(1'b1, 1'b0, "pre_rst_high");
    q = 1'b1;
    @(posedge clk);
    model_clock(1, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    check("async_rst.rise_zero", 32'(rise_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(1'b1, 1'b0, "post_rst_rise");
    check("post_rst.rise_cnt", 32'(rise_cnt), 32'd1);

    // Step 8: random level bursts, some long enough to time out, with rare clr.
    for (int seg = 0; seg < 300; seg++) begin
      lvl = int'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 40))
                                        : int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        tick(lvl[0], ($urandom_range(0, 49) == 0), "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
